// File: rtl/acumulador_multimodo.sv
// Two-stage pipelined multimode accumulator: stage 1 registers the operand sum and
// operation, stage 2 applies hold/add/subtract/load with wrap or saturate arithmetic.
module acumulador_multimodo #(
    parameter int unsigned NB_DATA = 3,
    parameter int unsigned NB_ACC  = 2 * NB_DATA,
    parameter int unsigned NB_WRAP = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic [NB_DATA-1:0] i_data2,
    input  logic [1:0]         i_sel,
    input  logic               i_sat,
    input  logic               i_clear,
    output logic [NB_ACC-1:0]  o_data,
    output logic               o_valid,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic [NB_WRAP-1:0] o_wrap_cnt
);

    localparam int unsigned NB_SUM = NB_DATA + 1;
    localparam int unsigned NB_RES = NB_ACC + 1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    logic [NB_SUM-1:0]  sum_in;

    logic               s1_valid_q;
    logic [NB_SUM-1:0]  s1_sum_q;
    op_e                s1_op_q;
    logic               s1_sat_q;

    logic [NB_ACC-1:0]  acc_q,   acc_d;
    logic               valid_q, valid_d;
    logic               ovf_q,   ovf_d;
    logic               unf_q,   unf_d;
    logic [NB_WRAP-1:0] wrap_q,  wrap_d;

    logic [NB_ACC-1:0]  sum_ext;
    logic [NB_RES-1:0]  add_res;
    logic [NB_ACC-1:0]  sub_res;
    logic               borrow;
    logic               wrap_evt;

    assign sum_in = NB_SUM'(i_data1) + NB_SUM'(i_data2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_op_q    <= OP_HOLD;
            s1_sat_q   <= 1'b0;
        end else if (i_clear) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_op_q    <= OP_HOLD;
            s1_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_sum_q <= sum_in;
                s1_op_q  <= op_e'(i_sel);
                s1_sat_q <= i_sat;
            end
        end
    end

    // The add result carries one extra bit so the overflow test needs no separate carry.
    assign sum_ext = NB_ACC'(s1_sum_q);
    assign add_res = {1'b0, acc_q} + NB_RES'(s1_sum_q);
    assign sub_res = acc_q - sum_ext;
    assign borrow  = (sum_ext > acc_q);

    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wrap_evt = 1'b0;
        valid_d  = s1_valid_q;
        if (s1_valid_q) begin
            case (s1_op_q)
                OP_HOLD: acc_d = acc_q;
                OP_ADD: begin
                    if (add_res[NB_ACC]) begin
                        ovf_d = 1'b1;
                        if (s1_sat_q) begin
                            acc_d = '1;
                        end else begin
                            acc_d    = add_res[NB_ACC-1:0];
                            wrap_evt = 1'b1;
                        end
                    end else begin
                        acc_d = add_res[NB_ACC-1:0];
                    end
                end
                OP_SUB: begin
                    if (borrow) begin
                        unf_d = 1'b1;
                        if (s1_sat_q) begin
                            acc_d = '0;
                        end else begin
                            acc_d    = sub_res;
                            wrap_evt = 1'b1;
                        end
                    end else begin
                        acc_d = sub_res;
                    end
                end
                OP_LOAD: acc_d = sum_ext;
                default: acc_d = acc_q;
            endcase
        end
        wrap_d = wrap_q;
        if (wrap_evt && (wrap_q != '1)) begin
            wrap_d = wrap_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            wrap_q  <= '0;
        end else if (i_clear) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_data      = acc_q;
    assign o_valid     = valid_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_wrap_cnt  = wrap_q;

endmodule
